// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : SUP-1 microcoded fetch/execute sequencer driving the bus control word.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry_flag,
  input  logic                    zero_flag,
  output logic [STEP_WIDTH-1:0]   step,
  output logic                    hlt,
  output logic                    mi,
  output logic                    ri,
  output logic                    ro,
  output logic                    io,
  output logic                    ii,
  output logic                    ai,
  output logic                    ao,
  output logic                    eo,
  output logic                    su,
  output logic                    bi,
  output logic                    oi,
  output logic                    fi,
  output logic                    ce,
  output logic                    co,
  output logic                    jmp
);

  localparam logic [OPCODE_WIDTH-1:0] c_op_lda = OPCODE_WIDTH'(4'h0);
  localparam logic [OPCODE_WIDTH-1:0] c_op_add = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] c_op_sub = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] c_op_sta = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] c_op_ldi = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] c_op_jmp = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] c_op_jc  = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] c_op_jz  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] c_op_out = OPCODE_WIDTH'(4'he);
  localparam logic [OPCODE_WIDTH-1:0] c_op_hlt = OPCODE_WIDTH'(4'hf);

  localparam logic [STEP_WIDTH-1:0] c_t0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] c_t1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] c_t2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] c_t3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] c_t4 = STEP_WIDTH'(4);

  logic [STEP_WIDTH-1:0] r_step;
  logic                  r_halted;
  logic [STEP_WIDTH-1:0] w_last_step;

  always_comb begin
    w_last_step = c_t2;
    case (opcode)
      c_op_lda, c_op_sta: w_last_step = c_t3;
      c_op_add, c_op_sub: w_last_step = c_t4;
      default:            w_last_step = c_t2;
    endcase
  end

  // During fetch the opcode is stale, but every last step is >= T2 so fetch always advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= c_t0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (r_step == c_t2 && opcode == c_op_hlt) begin
        r_halted <= 1'b1;
      end else if (r_step >= w_last_step) begin
        r_step <= c_t0;
      end else begin
        r_step <= r_step + STEP_WIDTH'(1);
      end
    end
  end

  assign step = r_step;

  always_comb begin
    hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0; io = 1'b0; ii = 1'b0;
    ai  = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0;
    fi  = 1'b0; ce = 1'b0; co = 1'b0; jmp = 1'b0;
    if (r_halted) begin
      hlt = 1'b1;
    end else begin
      case (r_step)
        c_t0: begin co = 1'b1; mi = 1'b1; end
        c_t1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
        c_t2: begin
          case (opcode)
            c_op_lda, c_op_add, c_op_sub, c_op_sta: begin io = 1'b1; mi = 1'b1; end
            c_op_ldi: begin io = 1'b1; ai = 1'b1; end
            c_op_jmp: begin io = 1'b1; jmp = 1'b1; end
            c_op_jc:  begin io = 1'b1; jmp = carry_flag; end
            c_op_jz:  begin io = 1'b1; jmp = zero_flag; end
            c_op_out: begin ao = 1'b1; oi = 1'b1; end
            c_op_hlt: hlt = 1'b1;
            default: ;
          endcase
        end
        c_t3: begin
          case (opcode)
            c_op_lda:           begin ro = 1'b1; ai = 1'b1; end
            c_op_add, c_op_sub: begin ro = 1'b1; bi = 1'b1; end
            c_op_sta:           begin ao = 1'b1; ri = 1'b1; end
            default: ;
          endcase
        end
        c_t4: begin
          if (opcode == c_op_add || opcode == c_op_sub) begin
            eo = 1'b1; ai = 1'b1; fi = 1'b1;
            su = (opcode == c_op_sub);
          end
        end
        default: ;
      endcase
    end
  end

  // Only one participant may drive the shared bus in any microstep.
  assert property (@(posedge clk) disable iff (rst) $onehot0({co, ro, io, ao, eo}));

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Scoreboard bench for control_sequencer with an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       carry_flag, zero_flag;
  logic [2:0] step;
  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, fi, ce, co, jmp;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] FI  = 16'h0008, CE = 16'h0004, CO = 16'h0002, JMP = 16'h0001;
  localparam logic [15:0] BUS = CO | RO | IO | AO | EO;

  typedef struct packed {
    logic [15:0] cw;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step(step), .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai),
    .ao(ao), .eo(eo), .su(su), .bi(bi), .oi(oi), .fi(fi), .ce(ce), .co(co), .jmp(jmp)
  );

  always #5 clk = ~clk;

  // Instruction length in cycles, fetch included.
  function automatic int n_cycles(input logic [3:0] op);
    case (op)
      4'h0, 4'h3: return 4;
      4'h1, 4'h2: return 5;
      default:    return 3;
    endcase
  endfunction

  // Control word expected in cycle t of an instruction.
  function automatic logic [15:0] exp_word(input logic [3:0] op, input int t,
                                           input logic c, input logic z);
    if (t == 0) return CO | MI;
    if (t == 1) return RO | II | CE;
    case (op)
      4'h0:       return (t == 2) ? (IO | MI) : (RO | AI);
      4'h1, 4'h2: return (t == 2) ? (IO | MI) : (t == 3) ? (RO | BI)
                         : (EO | AI | FI | ((op == 4'h2) ? SU : 16'h0));
      4'h3:       return (t == 2) ? (IO | MI) : (AO | RI);
      4'h4:       return IO | AI;
      4'h5:       return IO | JMP;
      4'h6:       return IO | (c ? JMP : 16'h0);
      4'h7:       return IO | (z ? JMP : 16'h0);
      4'he:       return AO | OI;
      4'hf:       return HLT;
      default:    return 16'h0;
    endcase
  endfunction

  task automatic push(input logic [15:0] cw, input int st);
    exp_t e;
    e.cw = cw;
    e.st = 3'(st);
    sb.push_back(e);
  endtask

  task automatic reset_slot();
    @(posedge clk); #1;
    rst = 1'b1;
    opcode = 4'($urandom);
    push(CO | MI, 0);
  endtask

  // Runs one instruction; abort_at >= 0 replaces that cycle with a reset.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int abort_at);
    int lim;
    lim = (abort_at >= 0) ? abort_at : n_cycles(op);
    for (int t = 0; t < lim; t++) begin
      @(posedge clk); #1;
      rst        = 1'b0;
      opcode     = (t < 2) ? 4'($urandom) : op;
      carry_flag = (t == 2) ? c : 1'($urandom);
      zero_flag  = (t == 2) ? z : 1'($urandom);
      push(exp_word(op, t, carry_flag, zero_flag), t);
    end
    if (abort_at >= 0) reset_slot();
  endtask

  task automatic halted_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      opcode     = (i == 3) ? 4'h0 : 4'($urandom);
      carry_flag = 1'($urandom);
      zero_flag  = 1'($urandom);
      push(HLT, 2);
    end
  endtask

  // Monitor: outputs are settled by the falling edge.
  initial begin
    logic [15:0] act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, fi, ce, co, jmp};
        n_cmp++;
        if (act !== e.cw) begin
          n_fail++;
          $display("FAIL ctrl_word @%0t: got %04h expected %04h", $time, act, e.cw);
        end
        n_cmp++;
        if (step !== e.st) begin
          n_fail++;
          $display("FAIL step @%0t: got %0d expected %0d", $time, step, e.st);
        end
        n_cmp++;
        if ($countones(act & BUS) > 1) begin
          n_fail++;
          $display("FAIL bus_exclusive @%0t: drivers %04h expected at most one", $time, act & BUS);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
    @(posedge clk); #1;
    push(CO | MI, 0);

    run_instr(4'h0, 1'b0, 1'b0, -1);
    run_instr(4'h2, 1'b0, 1'b0, -1);
    run_instr(4'h6, 1'b1, 1'b0, -1);
    run_instr(4'h6, 1'b0, 1'b1, -1);
    run_instr(4'h7, 1'b0, 1'b1, -1);
    run_instr(4'h8, 1'b1, 1'b1, -1);
    for (int o = 0; o < 15; o++)
      run_instr(4'(o), 1'($urandom), 1'($urandom), -1);
    run_instr(4'h1, 1'b0, 1'b0, 3);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 19) == 0)
        run_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, n_cycles(op) - 1));
      else
        run_instr(op, 1'($urandom), 1'($urandom), -1);
    end

    run_instr(4'hf, 1'b0, 1'b0, -1);
    halted_cycles(12);
    reset_slot();
    run_instr(4'h5, 1'b0, 1'b0, -1);
    run_instr(4'h3, 1'b0, 1'b0, -1);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
